// File: rtl/multdiv_hilo_if.sv
// Request/response bundle between the execute stage and the multiply/divide
// unit. The pipeline side uses the master modport, the unit uses slave.
//
// Handshake: an op transfers on a rising clk edge where op_valid && op_ready
// && !stall && !flush. The requester holds op_valid, op_code, src_a and src_b
// stable until that edge. op_ready depends only on unit state, never on
// op_valid.
interface multdiv_hilo_if #(
    parameter int DATA_W = 32
);
    logic              op_valid;
    logic              op_ready;
    logic [2:0]        op_code;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              stall;
    logic              flush;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;
    logic              divzero_trap;
    logic              state_dbg;

    modport master (
        output op_valid, op_code, src_a, src_b, stall, flush,
        input  op_ready, busy, done, hi_out, lo_out, divzero_trap, state_dbg
    );

    modport slave (
        input  op_valid, op_code, src_a, src_b, stall, flush,
        output op_ready, busy, done, hi_out, lo_out, divzero_trap, state_dbg
    );
endinterface

// File: rtl/multdiv_hilo_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division, one bit per
// cycle over DATA_W cycles, on operand magnitudes with a final sign fix-up.
// MTHI/MTLO write HI/LO directly in one cycle.
// Optional macro MULTDIV_DIVZERO_TRAP_EN adds a divide-by-zero trap pulse.
// state_dbg exposes the FSM state (0 IDLE, 1 RUN).
module multdiv_hilo_unit #(
    parameter int DATA_W = 32
) (
    input logic            clk,
    input logic            reset_n,
    multdiv_hilo_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic               is_div;
    logic               neg_res;   // negate product / quotient at the end
    logic               neg_rem;   // negate remainder (dividend was negative)
    logic               div_zero;  // divisor was zero
    logic [DATA_W-1:0]  p_hi;      // product high half / partial remainder
    logic [DATA_W-1:0]  p_lo;      // multiplier shifting out / quotient shifting in
    logic [DATA_W-1:0]  b_reg;     // multiplicand magnitude / divisor magnitude
    logic [DATA_W-1:0]  hi_q;
    logic [DATA_W-1:0]  lo_q;
    logic               done_q;
    logic               trap_q;

    // operand magnitudes and sign flags for the op being offered
    logic               signed_op;
    logic               neg_a;
    logic               neg_b;
    logic [DATA_W-1:0]  mag_a;
    logic [DATA_W-1:0]  mag_b;

    // Two's-complement magnitude of signed operands; unsigned ops pass through.
    always_comb begin
        signed_op = (bus.op_code == OP_MULT) || (bus.op_code == OP_DIV);
        neg_a     = signed_op & bus.src_a[DATA_W-1];
        neg_b     = signed_op & bus.src_b[DATA_W-1];
        mag_a     = neg_a ? (-bus.src_a) : bus.src_a;
        mag_b     = neg_b ? (-bus.src_b) : bus.src_b;
    end

    // one iteration of the datapath and the sign-fixed final results
    logic [DATA_W-1:0]   addend;
    logic [DATA_W:0]     add_sum;
    logic [DATA_W:0]     rem_sh;
    logic [DATA_W:0]     rem_sub;
    logic                q_bit;
    logic [DATA_W-1:0]   nxt_hi;
    logic [DATA_W-1:0]   nxt_lo;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    // Next datapath step: shift-add for multiply, restoring subtract for divide.
    // The sign of rem_sub tells whether the trial subtraction succeeded, since
    // the partial remainder is always below the divisor.
    always_comb begin
        addend  = p_lo[0] ? b_reg : '0;
        add_sum = {1'b0, p_hi} + {1'b0, addend};
        rem_sh  = {p_hi, p_lo[DATA_W-1]};
        rem_sub = rem_sh - {1'b0, b_reg};
        q_bit   = ~rem_sub[DATA_W];
        if (is_div) begin
            nxt_hi = q_bit ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
            nxt_lo = {p_lo[DATA_W-2:0], q_bit};
        end else begin
            nxt_hi = add_sum[DATA_W:1];
            nxt_lo = {add_sum[0], p_lo[DATA_W-1:1]};
        end
        prod     = {nxt_hi, nxt_lo};
        prod_fix = neg_res ? (-prod) : prod;
        quo_fix  = div_zero ? '1 : (neg_res ? (-nxt_lo) : nxt_lo);
        rem_fix  = neg_rem ? (-nxt_hi) : nxt_hi;
    end

    // Control FSM, datapath registers and HI/LO. Flush has top priority, then
    // stall, then normal IDLE/RUN behaviour.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            counter  <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            p_hi     <= '0;
            p_lo     <= '0;
            b_reg    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            trap_q   <= 1'b0;
        end else if (bus.flush) begin
            state   <= ST_IDLE;
            counter <= '0;
            done_q  <= 1'b0;
            trap_q  <= 1'b0;
        end else if (bus.stall) begin
            done_q <= 1'b0;
            trap_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            trap_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.op_valid) begin
                        case (bus.op_code)
                            OP_MULT, OP_MULTU: begin
                                state    <= ST_RUN;
                                counter  <= CNT_W'(DATA_W);
                                is_div   <= 1'b0;
                                neg_res  <= neg_a ^ neg_b;
                                neg_rem  <= 1'b0;
                                div_zero <= 1'b0;
                                p_hi     <= '0;
                                p_lo     <= mag_b;
                                b_reg    <= mag_a;
                            end
                            OP_DIV, OP_DIVU: begin
                                state    <= ST_RUN;
                                counter  <= CNT_W'(DATA_W);
                                is_div   <= 1'b1;
                                neg_res  <= neg_a ^ neg_b;
                                neg_rem  <= neg_a;
                                div_zero <= (bus.src_b == '0);
                                p_hi     <= '0;
                                p_lo     <= mag_a;
                                b_reg    <= mag_b;
                            end
                            OP_MTHI: hi_q <= bus.src_a;
                            OP_MTLO: lo_q <= bus.src_a;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    p_hi    <= nxt_hi;
                    p_lo    <= nxt_lo;
                    counter <= counter - 1'b1;
                    if (counter == CNT_W'(1)) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                        if (is_div) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
`ifdef MULTDIV_DIVZERO_TRAP_EN
                            trap_q <= div_zero;
`endif
                        end else begin
                            hi_q <= prod_fix[2*DATA_W-1:DATA_W];
                            lo_q <= prod_fix[DATA_W-1:0];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.op_ready  = (state == ST_IDLE);
    assign bus.busy      = (state == ST_RUN);
    assign bus.done      = done_q;
    assign bus.hi_out    = hi_q;
    assign bus.lo_out    = lo_q;
    assign bus.state_dbg = state;

`ifdef MULTDIV_DIVZERO_TRAP_EN
    assign bus.divzero_trap = trap_q;
`else
    assign bus.divzero_trap = 1'b0;
`endif

endmodule

// File: tb/tb_multdiv_hilo_unit.sv
// Directed bench for multdiv_hilo_unit (DATA_W=32). Expected values are
// hand-computed constants; each comparison is an immediate assertion.
module tb_multdiv_hilo_unit;
    logic clk;
    logic reset_n;
    int   cmp_cnt;
    int   err_cnt;

    multdiv_hilo_if #(.DATA_W(32)) bus ();

    multdiv_hilo_unit #(.DATA_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef MULTDIV_DIVZERO_TRAP_EN
    localparam logic EXP_TRAP = 1'b1;
`else
    localparam logic EXP_TRAP = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present one op for exactly one edge
    task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.src_a    = a;
        bus.src_b    = b;
        tick();
        bus.op_valid = 1'b0;
    endtask

    // count edges after the accept edge until done is seen (bounded);
    // optionally stalls and/or flushes at given edge counts (-1 = never)
    task automatic wait_done(input int stall_at, input int stall_len, input int flush_at,
                             output int edges, output logic got_done, output logic got_trap);
        got_done = 1'b0;
        got_trap = 1'b0;
        edges    = 0;
        while (!got_done && edges < 100) begin
            if (edges == stall_at) bus.stall = 1'b1;
            if (edges == stall_at + stall_len) bus.stall = 1'b0;
            if (edges == flush_at) bus.flush = 1'b1;
            tick();
            edges++;
            if (bus.flush) begin
                bus.flush = 1'b0;
                break;
            end
            if (bus.done) begin
                got_done = 1'b1;
                got_trap = bus.divzero_trap;
            end
        end
        bus.stall = 1'b0;
    endtask

    initial begin
        int   n;
        logic gd;
        logic gt;
        cmp_cnt      = 0;
        err_cnt      = 0;
        reset_n      = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_code  = 3'd0;
        bus.src_a    = '0;
        bus.src_b    = '0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        tick();
        tick();
        chk("rst_hi", 64'(bus.hi_out), 64'h0);
        chk("rst_lo", 64'(bus.lo_out), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        chk("rst_done", 64'(bus.done), 64'h0);
        chk("rst_trap", 64'(bus.divzero_trap), 64'h0);
        reset_n = 1'b1;
        tick();
        chk("rst_ready", 64'(bus.op_ready), 64'h1);

        // MTHI then MTLO back to back
        bus.op_valid = 1'b1;
        bus.op_code  = 3'd4;
        bus.src_a    = 32'h1234;
        tick();
        chk("mthi_hi", 64'(bus.hi_out), 64'h1234);
        chk("mthi_lo", 64'(bus.lo_out), 64'h0);
        chk("mthi_ready", 64'(bus.op_ready), 64'h1);
        chk("mthi_done", 64'(bus.done), 64'h0);
        bus.op_code = 3'd5;
        bus.src_a   = 32'h5678;
        tick();
        bus.op_valid = 1'b0;
        chk("mtlo_hi", 64'(bus.hi_out), 64'h1234);
        chk("mtlo_lo", 64'(bus.lo_out), 64'h5678);
        chk("mtlo_ready", 64'(bus.op_ready), 64'h1);
        chk("mtlo_done", 64'(bus.done), 64'h0);

        // flush and stall block accept in IDLE; codes 6-7 are no-ops
        bus.flush = 1'b1;
        issue(3'd4, 32'hDEAD, 32'h0);
        bus.flush = 1'b0;
        chk("flush_blk_hi", 64'(bus.hi_out), 64'h1234);
        bus.stall = 1'b1;
        issue(3'd0, 32'h3, 32'h3);
        bus.stall = 1'b0;
        chk("stall_blk_busy", 64'(bus.busy), 64'h0);
        issue(3'd6, 32'hBEEF, 32'h1);
        chk("nop_busy", 64'(bus.busy), 64'h0);
        chk("nop_hilo", {32'(bus.hi_out), 32'(bus.lo_out)}, 64'h00001234_00005678);

        // MULT -3 * 7
        issue(3'd0, 32'hFFFFFFFD, 32'd7);
        chk("mult_busy", 64'(bus.busy), 64'h1);
        chk("mult_ready", 64'(bus.op_ready), 64'h0);
        wait_done(-1, 0, -1, n, gd, gt);
        chk("mult_done", 64'(gd), 64'h1);
        chk("mult_lat", 64'(n), 64'd32);
        chk("mult_hilo", {32'(bus.hi_out), 32'(bus.lo_out)}, 64'hFFFFFFFF_FFFFFFEB);
        tick();
        chk("mult_done_pulse", 64'(bus.done), 64'h0);

        // MULTU 0x10000 * 0x10000 = 2^32
        issue(3'd1, 32'h00010000, 32'h00010000);
        wait_done(-1, 0, -1, n, gd, gt);
        chk("multu_lat", 64'(n), 64'd32);
        chk("multu_hilo", {32'(bus.hi_out), 32'(bus.lo_out)}, 64'h00000001_00000000);

        // DIV -7 / 2
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_done(-1, 0, -1, n, gd, gt);
        chk("div_lat", 64'(n), 64'd32);
        chk("div_hilo", {32'(bus.hi_out), 32'(bus.lo_out)}, 64'hFFFFFFFF_FFFFFFFD);
        chk("div_trap", 64'(gt), 64'h0);

        // DIV MIN / -1
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done(-1, 0, -1, n, gd, gt);
        chk("div_min_hilo", {32'(bus.hi_out), 32'(bus.lo_out)}, 64'h00000000_80000000);

        // DIVU 100 / 7
        issue(3'd3, 32'd100, 32'd7);
        wait_done(-1, 0, -1, n, gd, gt);
        chk("divu_hilo", {32'(bus.hi_out), 32'(bus.lo_out)}, 64'h00000002_0000000E);

        // DIVU 7 / 0
        issue(3'd3, 32'd7, 32'd0);
        wait_done(-1, 0, -1, n, gd, gt);
        chk("divz_lat", 64'(n), 64'd32);
        chk("divz_hilo", {32'(bus.hi_out), 32'(bus.lo_out)}, 64'h00000007_FFFFFFFF);
        chk("divz_trap", 64'(gt), 64'(EXP_TRAP));
        tick();
        chk("divz_trap_pulse", 64'(bus.divzero_trap), 64'h0);

        // DIV -9 / 0: HI is the raw dividend
        issue(3'd2, 32'hFFFFFFF7, 32'd0);
        wait_done(-1, 0, -1, n, gd, gt);
        chk("divz_s_hilo", {32'(bus.hi_out), 32'(bus.lo_out)}, 64'hFFFFFFF7_FFFFFFFF);

        // MULTU FFFFFFFF * 2 with a 5-cycle stall mid-run
        issue(3'd1, 32'hFFFFFFFF, 32'd2);
        wait_done(10, 5, -1, n, gd, gt);
        chk("stall_lat", 64'(n), 64'd37);
        chk("stall_hilo", {32'(bus.hi_out), 32'(bus.lo_out)}, 64'h00000001_FFFFFFFE);

        // DIV flushed on its completion edge
        issue(3'd2, 32'd100, 32'd7);
        wait_done(-1, 0, 31, n, gd, gt);
        chk("flush_edges", 64'(n), 64'd32);
        chk("flush_done", 64'(bus.done), 64'h0);
        chk("flush_busy", 64'(bus.busy), 64'h0);
        chk("flush_hilo", {32'(bus.hi_out), 32'(bus.lo_out)}, 64'h00000001_FFFFFFFE);
        tick();
        chk("flush_done_after", 64'(bus.done), 64'h0);
        chk("flush_ready", 64'(bus.op_ready), 64'h1);

        // reset in the middle of a MULT
        issue(3'd0, 32'd5, 32'd5);
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'h0);
        chk("midrst_hilo", {32'(bus.hi_out), 32'(bus.lo_out)}, 64'h0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("midrst_ready", 64'(bus.op_ready), 64'h1);
        chk("midrst_done", 64'(bus.done), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
